// File: rtl/mem_bank_responder.sv
`timescale 1ns/1ps
// Four-bank word-interleaved 16-bit memory responder: 2-cycle read latency, per-bank busy window.
// Optional malformed-request checking is enabled by defining MEM_REQ_CHECK_EN.
module mem_bank_responder #(
  parameter int ADDR_W   = 16,
  parameter int BUSY_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_data_in,
  output logic [15:0]       o_data_out,
  output logic              o_data_valid,
  output logic              o_stall,
  output logic [3:0]        o_busy,
  output logic              o_err
);

  localparam int         ROWS     = 1 << (ADDR_W - 3);
  localparam logic [2:0] CNT_LOAD = 3'(BUSY_CYC - 1);

  logic [15:0] r_mem [4][ROWS];
  logic [2:0]  r_cnt [4];
  logic        r_s1_vld;
  logic        r_s2_vld;
  logic [15:0] r_s1_data;
  logic [15:0] r_s2_data;

  logic              w_req;
  logic              w_bad;
  logic [1:0]        w_bank;
  logic [ADDR_W-4:0] w_row;
  logic [3:0]        w_busy;
  logic              w_accept;
  logic              w_acc_wr;
  logic              w_acc_rd;

  assign w_req  = i_rd | i_wr;
  assign w_bank = i_addr[2:1];
  assign w_row  = i_addr[ADDR_W-1:3];

`ifdef MEM_REQ_CHECK_EN
  assign w_bad = w_req & (i_addr[0] | (i_rd & i_wr));
`else
  // byte-lane bit carries no meaning in this build
  assign w_bad = 1'b0 & i_addr[0];
`endif

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_busy[n] = (r_cnt[n] != 3'd0);
    end
  end

  assign o_stall  = w_req & ~w_bad & w_busy[w_bank];
  assign w_accept = w_req & ~w_bad & ~o_stall;
  // rd&wr together (unchecked build) behaves as a write; the read half is dropped
  assign w_acc_wr = w_accept & i_wr & i_rst;
  assign w_acc_rd = w_accept & i_rd & ~i_wr;

  always_ff @(posedge i_clk) begin
    if (w_acc_wr) begin
      r_mem[w_bank][w_row] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int n = 0; n < 4; n++) begin
        r_cnt[n] <= 3'd0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_accept && (w_bank == 2'(n))) begin
          r_cnt[n] <= CNT_LOAD;
        end else if (r_cnt[n] != 3'd0) begin
          r_cnt[n] <= r_cnt[n] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s1_data <= 16'h0000;
      r_s2_data <= 16'h0000;
    end else begin
      r_s1_vld  <= w_acc_rd;
      r_s1_data <= r_mem[w_bank][w_row];
      r_s2_vld  <= r_s1_vld;
      r_s2_data <= r_s1_data;
    end
  end

  assign o_data_valid = r_s2_vld;
  assign o_data_out   = r_s2_vld ? r_s2_data : 16'h0000;
  assign o_busy       = w_busy;
  assign o_err        = w_bad;

endmodule

// File: tb/tb_mem_bank_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_bank_responder: expected read data queued at accept, checked on data_valid.
module tb_mem_bank_responder;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dvalid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  mem_bank_responder #(.ADDR_W(16), .BUSY_CYC(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd        (rd),
    .i_wr        (wr),
    .i_addr      (addr),
    .i_data_in   (din),
    .o_data_out  (dout),
    .o_data_valid(dvalid),
    .o_stall     (stall),
    .o_busy      (busy),
    .o_err       (err)
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model [int];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          run_mon = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // read-data monitor: each data_valid must match the oldest queued read, on its due cycle
  always @(negedge clk) begin
    if (run_mon) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        total++; bad++;
        $display("FAIL missed_read: no data_valid at cycle %0d, required data %h", q[0].due, q[0].data);
        void'(q.pop_front());
      end
      if (dvalid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: data_valid=1 data_out=%h at cycle %0d, required no read", dout, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (dout !== e.data || cyc != e.due) begin
            bad++;
            $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d", dout, cyc, e.data, e.due);
          end
        end
      end else if (dvalid !== 1'b0 || dout !== 16'h0000) begin
        total++; bad++;
        $display("FAIL idle_out: data_valid=%b data_out=%h, required 0/0000", dvalid, dout);
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rd = 0; wr = 0;
      @(negedge clk);
    end
  endtask

  task automatic do_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int exp_stalls, input string name);
    int n = 0;
    bit done = 0;
    for (int k = 0; k < 16 && !done; k++) begin
      @(posedge clk); #1;
      rd = r; wr = w; addr = a; din = d;
      @(negedge clk);
      if (stall === 1'b1) n++;
      else begin
        done = 1;
        if (w) model[int'(a >> 1)] = d;
        else if (r) q.push_back('{model[int'(a >> 1)], cyc + 2});
      end
    end
    total++;
    if (!done || n != exp_stalls) begin
      bad++;
      $display("FAIL %s_stalls: accepted=%0d stall cycles=%0d, required accept after %0d", name, done, n, exp_stalls);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL %s_err: err=%b, required 0", name, err);
    end
  endtask

  task automatic check_busy(input logic [3:0] e, input string name);
    total++;
    if (busy !== e) begin
      bad++;
      $display("FAIL %s: busy=%b, required %b", name, busy, e);
    end
  endtask

  task automatic test_reset();
    rst = 0; rd = 0; wr = 0; addr = 0; din = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    total++;
    if (dvalid !== 0 || dout !== 0 || stall !== 0 || busy !== 0 || err !== 0) begin
      bad++;
      $display("FAIL reset_outs: dv=%b do=%h st=%b busy=%b err=%b, required all 0", dvalid, dout, stall, busy, err);
    end
    run_mon = 1;
  endtask

  task automatic test_burst_fill();
    logic [3:0] exp_b [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
    logic [15:0] data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 4; k++) begin
      do_req(0, 1, 16'h0A40 + 16'(2 * k), data[k], 0, "fill");
      check_busy(exp_b[k], "fill_busy");
    end
    idle(1);
    check_busy(4'b1110, "fill_busy_after");
    idle(3);
  endtask

  task automatic test_burst_read();
    for (int k = 0; k < 4; k++) do_req(1, 0, 16'h0A40 + 16'(2 * k), 16'h0, 0, "burst_rd");
    idle(4);
  endtask

  task automatic test_conflict();
    do_req(0, 1, 16'h0108, 16'h7E57, 0, "pre_wr");
    idle(4);
    do_req(0, 1, 16'h0100, 16'h0C0C, 0, "conf_wr");
    do_req(1, 0, 16'h0108, 16'h0, 3, "conf_rd");
    idle(4);
  endtask

  task automatic test_raw();
    do_req(0, 1, 16'h2002, 16'hBEEF, 0, "raw_wr");
    idle(3);
    do_req(1, 0, 16'h2002, 16'h0, 0, "raw_rd");
    idle(4);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    rd = 1; wr = 0; addr = 16'h0A44;
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_accept: stall=%b, required 0", stall);
    end
    @(posedge clk); #1;
    rd = 0; rst = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    total++;
    if (busy !== 4'b0000 || dvalid !== 1'b0 || dout !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_state: busy=%b dv=%b do=%h, required 0000/0/0000", busy, dvalid, dout);
    end
    do_req(1, 0, 16'h0A46, 16'h0, 0, "post_rst_rd");
    idle(4);
  endtask

  task automatic test_malformed();
`ifdef MEM_REQ_CHECK_EN
    do_req(0, 1, 16'h0010, 16'h1234, 0, "mal_pre");
    idle(4);
    @(posedge clk); #1;
    rd = 1; wr = 1; addr = 16'h0010; din = 16'hFFFF;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || stall !== 1'b0 || busy !== 4'b0000) begin
      bad++;
      $display("FAIL mal_rdwr: err=%b stall=%b busy=%b, required 1/0/0000", err, stall, busy);
    end
    @(posedge clk); #1;
    rd = 1; wr = 0; addr = 16'h0011;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || stall !== 1'b0 || busy !== 4'b0000) begin
      bad++;
      $display("FAIL mal_odd: err=%b stall=%b busy=%b, required 1/0/0000", err, stall, busy);
    end
    idle(1);
    check_busy(4'b0000, "mal_busy_after");
    do_req(1, 0, 16'h0010, 16'h0, 0, "mal_readback");
`else
    do_req(1, 1, 16'h0010, 16'h5A5A, 0, "rdwr_write");
    idle(4);
    do_req(1, 0, 16'h0010, 16'h0, 0, "rdwr_readback");
`endif
    idle(4);
  endtask

  initial begin
    test_reset();
    test_burst_fill();
    test_burst_read();
    test_conflict();
    test_raw();
    test_reset_mid();
    test_malformed();
    idle(2);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d reads still pending, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1);
  end

endmodule
